// File: rtl/add_share_arbiter.sv
// add_share_arbiter
// Round-robin arbiter that time-shares one external combinational adder
// among N_REQ requesters. The winning requester's operands are driven onto
// add_x/add_y, and the returned sum is captured into a single-entry response
// buffer tagged with the requester index.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   req          per-requester request, held with stable operands until granted
//   req_x/req_y  packed operands, slice i belongs to requester i
//   gnt          one-hot combinational grant (request accepted when gnt[i]=1)
//   add_x/add_y  operands to the shared adder
//   add_z        sum returned by the shared adder (combinational)
//   resp_valid   response buffer holds a result
//   resp_id      owner of resp_z
//   resp_z       registered sum
//   resp_ready   consumer accepts the response when resp_valid & resp_ready
//   grant_cnt    saturating count of grants since reset
module add_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       add_x,
    output logic [WIDTH-1:0]       add_y,
    input  logic [WIDTH-1:0]       add_z,
    output logic                   resp_valid,
    output logic [IDW-1:0]         resp_id,
    output logic [WIDTH-1:0]       resp_z,
    input  logic                   resp_ready,
    output logic [CNTW-1:0]        grant_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             armed_q;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win;
    logic             win_found;
    logic             slot_free;
    logic             grant;
    int unsigned      idx;
    logic [WIDTH-1:0] sel_x, sel_y;
    logic [WIDTH-1:0] hold_x_q, hold_y_q;

    assign resp_valid = (state_q == FULL);

    // Rotating priority scan starting at ptr_q.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!win_found && req[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win       = idx[IDW-1:0];
            end
        end
    end

    assign sel_x = req_x[int'(win)*WIDTH +: WIDTH];
    assign sel_y = req_y[int'(win)*WIDTH +: WIDTH];

    // Next state, grant and adder drive. armed_q keeps requests masked until
    // the first clock edge after reset release; when no grant is issued the
    // adder operands stay at the last granted pair.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt       = '0;
        add_x     = hold_x_q;
        add_y     = hold_y_q;
        slot_free = (state_q == EMPTY) || resp_ready;
        grant     = armed_q && slot_free && win_found;

        if (grant) begin
            gnt[win] = 1'b1;
            add_x    = sel_x;
            add_y    = sel_y;
            ptr_d    = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end

        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (resp_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            armed_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_z    <= '0;
            resp_id   <= '0;
            hold_x_q  <= '0;
            hold_y_q  <= '0;
            grant_cnt <= '0;
        end else if (grant) begin
            resp_z   <= add_z;
            resp_id  <= win;
            hold_x_q <= sel_x;
            hold_y_q <= sel_y;
            if (grant_cnt != '1) begin
                grant_cnt <= grant_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
module tb_add_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_x, req_y;
    logic [3:0]  gnt;
    logic [7:0]  add_x, add_y, add_z;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [7:0]  resp_z;
    logic        resp_ready;
    logic [15:0] grant_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Shared combinational adder, carry dropped.
    assign add_z = add_x + add_y;

    add_share_arbiter #(.N_REQ(4), .WIDTH(8), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .add_x(add_x), .add_y(add_y), .add_z(add_z),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_z(resp_z),
        .resp_ready(resp_ready), .grant_cnt(grant_cnt)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] xs;
        logic [31:0] ys;
        logic        rdy;
        logic [3:0]  e_gnt;
        logic        e_valid;
        logic [1:0]  e_id;
        logic [7:0]  e_z;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] xs, input logic [31:0] ys,
                                input logic rdy, input logic [3:0] g, input logic v,
                                input logic [1:0] id, input logic [7:0] z, input logic [15:0] cnt);
        vec_t t;
        t.req = r; t.xs = xs; t.ys = ys; t.rdy = rdy;
        t.e_gnt = g; t.e_valid = v; t.e_id = id; t.e_z = z; t.e_cnt = cnt;
        return t;
    endfunction

    // Reset then one clock edge with no requests (requests are ignored on it).
    task automatic do_reset();
        req = '0; req_x = '0; req_y = '0; resp_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase.
    int unsigned m_ptr, m_cnt, m_id, m_z, m_hx, m_hy;
    bit          m_valid;

    initial begin
        logic [31:0] allx, ally;
        allx = pk(0, 1, 2, 3);
        ally = pk(10, 10, 10, 10);

        // Reset state, checked asynchronously before any clock edge.
        req = '0; req_x = '0; req_y = '0; resp_ready = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst.valid", resp_valid, 0);
        chk("rst.id", resp_id, 0);
        chk("rst.z", resp_z, 0);
        chk("rst.cnt", grant_cnt, 0);
        chk("rst.gnt", gnt, 0);
        chk("rst.add_x", add_x, 0);
        chk("rst.add_y", add_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table: inputs, comb grant, registered response.
        vecs.push_back(mk(4'b0001, pk(1, 0, 0, 0), pk(2, 0, 0, 0), 1, 4'b0001, 1, 0, 3, 1));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 0, 0, 3, 1));
        vecs.push_back(mk(4'b0001, pk(35, 0, 0, 0), pk(10, 0, 0, 0), 1, 4'b0001, 1, 0, 45, 2));
        vecs.push_back(mk(4'b0100, pk(0, 0, 200, 0), pk(0, 0, 100, 0), 1, 4'b0100, 1, 2, 44, 3));
        vecs.push_back(mk(4'b0100, pk(0, 0, 255, 0), pk(0, 0, 1, 0), 1, 4'b0100, 1, 2, 0, 4));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 0, 2, 0, 4));
        vecs.push_back(mk(4'b1000, allx, ally, 1, 4'b1000, 1, 3, 13, 5));
        vecs.push_back(mk(4'b1111, allx, ally, 1, 4'b0001, 1, 0, 10, 6));
        vecs.push_back(mk(4'b1111, allx, ally, 1, 4'b0010, 1, 1, 11, 7));
        vecs.push_back(mk(4'b1111, allx, ally, 1, 4'b0100, 1, 2, 12, 8));
        vecs.push_back(mk(4'b1111, allx, ally, 1, 4'b1000, 1, 3, 13, 9));
        vecs.push_back(mk(4'b1111, allx, ally, 1, 4'b0001, 1, 0, 10, 10));
        vecs.push_back(mk(4'b1111, allx, ally, 1, 4'b0010, 1, 1, 11, 11));
        vecs.push_back(mk(4'b0001, allx, ally, 1, 4'b0001, 1, 0, 10, 12));
        vecs.push_back(mk(4'b1010, allx, ally, 1, 4'b0010, 1, 1, 11, 13));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b1010, allx, ally, 0, 4'b0000, 1, 1, 11, 13));
        vecs.push_back(mk(4'b1010, allx, ally, 1, 4'b1000, 1, 3, 13, 14));
        vecs.push_back(mk(4'b0000, allx, ally, 1, 4'b0000, 0, 3, 13, 14));
        // Withdrawn request: req[1] appears only while stalled.
        vecs.push_back(mk(4'b0001, pk(5, 0, 0, 0), pk(5, 0, 0, 0), 0, 4'b0001, 1, 0, 10, 15));
        vecs.push_back(mk(4'b0010, allx, ally, 0, 4'b0000, 1, 0, 10, 15));
        vecs.push_back(mk(4'b0000, allx, ally, 0, 4'b0000, 1, 0, 10, 15));
        vecs.push_back(mk(4'b0000, allx, ally, 1, 4'b0000, 0, 0, 10, 15));
        // Pointer still at 1: requester 1 must win over 2.
        vecs.push_back(mk(4'b0110, allx, ally, 1, 4'b0010, 1, 1, 11, 16));

        foreach (vecs[i]) begin
            req = vecs[i].req; req_x = vecs[i].xs; req_y = vecs[i].ys; resp_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.gnt", i), gnt, vecs[i].e_gnt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), resp_valid, vecs[i].e_valid);
            chk($sformatf("v%0d.id", i), resp_id, vecs[i].e_id);
            chk($sformatf("v%0d.z", i), resp_z, vecs[i].e_z);
            chk($sformatf("v%0d.cnt", i), grant_cnt, vecs[i].e_cnt);
        end

        // Async reset mid-operation with resp_z=45 held.
        req = 4'b0001; req_x = pk(35, 0, 0, 0); req_y = pk(10, 0, 0, 0); resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ar.pre_z", resp_z, 45);
        chk("ar.pre_valid", resp_valid, 1);
        req = '0; resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.valid", resp_valid, 0);
        chk("ar.z", resp_z, 0);
        chk("ar.cnt", grant_cnt, 0);
        chk("ar.id", resp_id, 0);
        @(posedge clk);
        #2;
        req = 4'b1111; req_x = allx; req_y = ally; resp_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar.gnt_masked", gnt, 0);
        @(posedge clk);
        #1;
        chk("ar.valid_after_arm", resp_valid, 0);
        @(negedge clk);
        chk("ar.first_gnt", gnt, 4'b0001);
        @(posedge clk);
        #1;
        chk("ar.first_id", resp_id, 0);
        chk("ar.first_z", resp_z, 10);
        chk("ar.first_cnt", grant_cnt, 1);

        // Randomized phase against a behavioural model.
        do_reset();
        m_ptr = 0; m_cnt = 0; m_id = 0; m_z = 0; m_hx = 0; m_hy = 0; m_valid = 0;
        for (int c = 0; c < 400; c++) begin
            bit          slot, g;
            int unsigned w;
            logic [3:0]  exp_g;
            logic [7:0]  xv[4], yv[4];
            req = 4'($urandom_range(0, 15));
            req_x = $urandom;
            req_y = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                xv[i] = req_x[i*8 +: 8];
                yv[i] = req_y[i*8 +: 8];
            end
            slot = !m_valid || resp_ready;
            g = 0; w = 0;
            for (int k = 0; k < 4; k++) begin
                int unsigned i;
                i = (m_ptr + k) % 4;
                if (!g && req[i] && slot) begin
                    g = 1; w = i;
                end
            end
            exp_g = g ? 4'(1 << w) : 4'b0000;
            @(negedge clk);
            chk($sformatf("r%0d.gnt", c), gnt, exp_g);
            chk($sformatf("r%0d.add_x", c), add_x, g ? xv[w] : m_hx);
            chk($sformatf("r%0d.add_y", c), add_y, g ? yv[w] : m_hy);
            @(posedge clk);
            #1;
            if (g) begin
                m_z = (xv[w] + yv[w]) % 256;
                m_id = w;
                m_valid = 1;
                m_ptr = (w + 1) % 4;
                m_hx = xv[w];
                m_hy = yv[w];
                if (m_cnt < 65535) m_cnt++;
            end else if (resp_ready) begin
                m_valid = 0;
            end
            chk($sformatf("r%0d.valid", c), resp_valid, m_valid);
            chk($sformatf("r%0d.id", c), resp_id, m_id);
            chk($sformatf("r%0d.z", c), resp_z, m_z);
            chk($sformatf("r%0d.cnt", c), grant_cnt, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
